dpcm_decompressor: RTL and testbench

- Streaming decoder: 16-bit DPCM codes (R5/G6/B5 signed residuals) in, 24-bit RGB888 pixels out, raster order, one pixel per accepted code.
- Sits on the frame-buffer read path, ahead of the display pipeline.
- Rebuilds each pixel from the left and up neighbours it has already reconstructed, using the same predictor and mod-256 arithmetic as the team's DPCM compressor. Output is bit-exact with the compressor's internal reconstruction.

---
 rtl/dpcm_decompressor.sv | 113 +++++++++++
 tb/tb_dpcm_decompressor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpcm_decompressor.sv
// DPCM decoder: 16-bit R5/G6/B5 residual codes in, RGB888 pixels out, raster order.
// Optional DPCM_DECOMP_SOF_SYNC_EN adds i_sof frame resync and o_resync.
module dpcm_decompressor #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int CW     = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
`ifdef DPCM_DECOMP_SOF_SYNC_EN
  input  logic        i_sof,
  output logic        o_resync,
`endif
  output logic        o_valid,
  output logic [23:0] o_data,
  output logic        o_sof,
  output logic        o_eof
);

  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_ROW = CW'(HEIGHT - 1);
  localparam logic [23:0]   MID      = 24'h7F7F7F;

  logic [CW-1:0] row, col;
  logic [CW-1:0] erow, ecol;
  logic [CW-1:0] nrow, ncol;
  logic [23:0]   left;
  logic [23:0]   lp, up;
  logic [23:0]   pix;
  logic          sync;
  logic [23:0]   lbuf [WIDTH];

`ifdef DPCM_DECOMP_SOF_SYNC_EN
  assign sync = i_sof;
`else
  assign sync = 1'b0;
`endif

  function automatic logic [7:0] avg(
    input logic [7:0] l,
    input logic [7:0] u
  );
    logic [8:0] s;
    s = {1'b0, l} + {1'b0, u};
    return s[8:1];
  endfunction

  // A resync code is decoded as if the counters stood at the frame origin
  assign erow = sync ? '0 : row;
  assign ecol = sync ? '0 : col;

  always_comb begin
    lp = (ecol == '0) ? MID : left;
    up = (erow == '0) ? MID : lbuf[ecol];
    pix[23:16] = avg(lp[23:16], up[23:16])
               + {i_data[15:11], 3'b000};
    pix[15:8]  = avg(lp[15:8], up[15:8])
               + {i_data[10:5], 2'b00};
    pix[7:0]   = avg(lp[7:0], up[7:0])
               + {i_data[4:0], 3'b000};
  end

  always_comb begin
    nrow = erow;
    ncol = ecol + 1'b1;
    if (ecol == LAST_COL) begin
      ncol = '0;
      nrow = (erow == LAST_ROW) ? '0 : erow + 1'b1;
    end
  end

  // Read above is combinational, so this write is read-before-write
  always_ff @(posedge i_clk) begin
    if (i_valid) lbuf[ecol] <= pix;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row     <= '0;
      col     <= '0;
      left    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        row    <= nrow;
        col    <= ncol;
        left   <= pix;
        o_data <= pix;
        o_sof  <= (erow == '0) && (ecol == '0);
        o_eof  <= (erow == LAST_ROW) && (ecol == LAST_COL);
      end
    end
  end

`ifdef DPCM_DECOMP_SOF_SYNC_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resync <= 1'b0;
    end else if (i_valid) begin
      o_resync <= sync && ((row != '0) || (col != '0));
    end else begin
      o_resync <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dpcm_decompressor.sv
// Bench for dpcm_decompressor on a 4x3 frame: directed codes plus
// compressor-model loopback, checked through an expected-output queue.
module tb_dpcm_decompressor;

  localparam int W = 4;
  localparam int H = 3;

  typedef struct packed {
    logic [23:0] d;
    logic        s;
    logic        e;
    logic        rs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_data = 16'h0;
  logic        o_valid;
  logic [23:0] o_data;
  logic        o_sof;
  logic        o_eof;
`ifdef DPCM_DECOMP_SOF_SYNC_EN
  logic        sof_in = 1'b0;
  logic        o_resync;
`endif

  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic exp_v;

  int mrow = 0;
  int mcol = 0;
  logic [23:0] mpix [H][W];

  dpcm_decompressor #(.WIDTH(W), .HEIGHT(H), .CW(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .i_data  (i_data),
`ifdef DPCM_DECOMP_SOF_SYNC_EN
    .i_sof   (sof_in),
    .o_resync(o_resync),
`endif
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_sof   (o_sof),
    .o_eof   (o_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= i_valid;
  end

  always @(negedge clk) begin
    exp_t e;
    total++;
    assert (o_valid === exp_v) else begin
      bad++;
      $error("FAIL valid got=%b want=%b", o_valid, exp_v);
    end
    if (o_valid === 1'b1) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL extra_out got=%h want=none", o_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        total++;
        assert ({o_data, o_sof, o_eof} === {e.d, e.s, e.e}) else begin
          bad++;
          $error("FAIL pixel got=%h/%b/%b want=%h/%b/%b",
                 o_data, o_sof, o_eof, e.d, e.s, e.e);
        end
`ifdef DPCM_DECOMP_SOF_SYNC_EN
        total++;
        assert (o_resync === e.rs) else begin
          bad++;
          $error("FAIL resync got=%b want=%b", o_resync, e.rs);
        end
`endif
      end
    end
  end

  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8:1];
  endfunction

  function automatic logic [23:0] predict(input int r, input int c);
    logic [23:0] l, u;
    l = 24'h7F7F7F;
    u = 24'h7F7F7F;
    if (c > 0) l = mpix[r][c-1];
    if (r > 0) u = mpix[r-1][c];
    return {avg(l[23:16], u[23:16]), avg(l[15:8], u[15:8]), avg(l[7:0], u[7:0])};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one code; expectation is either given constants or the frame model
  task automatic send(input logic [15:0] code, input bit sof, input bit use_k,
                      input logic [23:0] kd, input bit ks, input bit ke);
    exp_t e;
    int r, c;
    logic [23:0] p, px;
    e.rs = sof && !(mrow == 0 && mcol == 0);
    if (sof) begin
      mrow = 0;
      mcol = 0;
    end
    r = mrow;
    c = mcol;
    p = predict(r, c);
    px[23:16] = p[23:16] + {code[15:11], 3'b000};
    px[15:8]  = p[15:8] + {code[10:5], 2'b00};
    px[7:0]   = p[7:0] + {code[4:0], 3'b000};
    mpix[r][c] = px;
    e.d = use_k ? kd : px;
    e.s = use_k ? ks : (r == 0 && c == 0);
    e.e = use_k ? ke : (r == H-1 && c == W-1);
    q.push_back(e);
    mcol = mcol + 1;
    if (mcol == W) begin
      mcol = 0;
      mrow = (mrow == H-1) ? 0 : mrow + 1;
    end
    i_valid = 1'b1;
    i_data = code;
`ifdef DPCM_DECOMP_SOF_SYNC_EN
    sof_in = sof;
`endif
    @(posedge clk);
    #1;
    i_valid = 1'b0;
`ifdef DPCM_DECOMP_SOF_SYNC_EN
    sof_in = 1'b0;
`endif
  endtask

  // Compressor model: quantise pix against the model's own reconstruction
  task automatic encode(input logic [23:0] pix, input bit sof);
    int r, c;
    logic [23:0] p, d;
    r = sof ? 0 : mrow;
    c = sof ? 0 : mcol;
    p = predict(r, c);
    d[23:16] = pix[23:16] - p[23:16];
    d[15:8]  = pix[15:8] - p[15:8];
    d[7:0]   = pix[7:0] - p[7:0];
    send({d[23:19], d[15:10], d[7:3]}, sof, 1'b0, 24'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input bit drain);
    if (drain) idle(2);
    rst_n = 1'b0;
    #1;
    total++;
    assert (o_valid === 1'b0) else begin
      bad++;
      $error("FAIL rst_valid got=%b want=0", o_valid);
    end
    q.delete();
    mrow = 0;
    mcol = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    total++;
    assert ({o_valid, o_data, o_sof, o_eof} === 27'h0) else begin
      bad++;
      $error("FAIL reset_state got=%b/%h/%b/%b want=0", o_valid, o_data, o_sof, o_eof);
    end
    rst_n = 1'b1;
    idle(1);

    send(16'h0000, 1'b0, 1'b1, 24'h7F7F7F, 1'b1, 1'b0);
    do_reset(1'b1);
    send(16'h7BEF, 1'b0, 1'b1, 24'hF7FBF7, 1'b1, 1'b0);
    do_reset(1'b1);
    send(16'hF800, 1'b0, 1'b1, 24'h777F7F, 1'b1, 1'b0);
    send(16'h0000, 1'b0, 1'b1, 24'h7B7F7F, 1'b0, 1'b0);

    send(16'h1234, 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
    do_reset(1'b0);
    send(16'h0000, 1'b0, 1'b1, 24'h7F7F7F, 1'b1, 1'b0);

    do_reset(1'b1);
    for (int i = 0; i < W*H; i++) begin
      send(16'($urandom), 1'b0, 1'b0, 24'h0, 1'b0, 1'b0);
      idle($urandom_range(0, 2));
    end
    send(16'h0000, 1'b0, 1'b1, 24'h7F7F7F, 1'b1, 1'b0);

    for (int f = 0; f < 4*W*H - 1; f++) begin
      encode(24'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end

`ifdef DPCM_DECOMP_SOF_SYNC_EN
    encode(24'($urandom), 1'b0);
    encode(24'($urandom), 1'b0);
    encode(24'($urandom), 1'b1);
    for (int i = 0; i < W*H; i++) encode(24'($urandom), 1'b0);
`endif

    idle(3);
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
